// File: rtl/shift_counter_register.sv
// Parametrised shift register with frame bit counter, completion strobe and held last word.
// Optional build macro SHREG_PARITY_EN adds a parity output over each completed word.
module shift_counter_register #(
    parameter int WIDTH = 8,
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             set,
    input  logic             load,
    input  logic             dir,
    input  logic             si,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] so,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             co,
`ifdef SHREG_PARITY_EN
    output logic             parity,
`endif
    output logic [WIDTH-1:0] word
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    function automatic logic xor_reduce(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    logic [WIDTH-1:0] r_so;
    logic [CW-1:0]    r_cnt;
    logic             r_co;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_so_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_co_nxt;
    logic [WIDTH-1:0] w_word_nxt;
    logic             w_wrap;

    // Next-state selection: set beats load beats shift; a wrap only completes on a plain shift
    always_comb begin
        w_shifted  = dir ? {si, r_so[WIDTH-1:1]} : {r_so[WIDTH-2:0], si};
        w_so_nxt   = r_so;
        w_cnt_nxt  = r_cnt;
        w_co_nxt   = 1'b0;
        w_word_nxt = r_word;
        w_wrap     = 1'b0;
        if (set) begin
            w_so_nxt  = '0;
            w_cnt_nxt = '0;
        end else if (load) begin
            w_so_nxt  = pin;
            w_cnt_nxt = '0;
        end else if (en) begin
            w_so_nxt = w_shifted;
            if (r_cnt == CNT_MAX) begin
                w_cnt_nxt  = '0;
                w_co_nxt   = 1'b1;
                w_word_nxt = w_shifted;
                w_wrap     = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            w_so_nxt = r_so;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_so   <= '0;
            r_cnt  <= '0;
            r_co   <= 1'b0;
            r_word <= '0;
        end else begin
            r_so   <= w_so_nxt;
            r_cnt  <= w_cnt_nxt;
            r_co   <= w_co_nxt;
            r_word <= w_word_nxt;
        end
    end

`ifdef SHREG_PARITY_EN
    logic r_parity;

    // Parity tracks the word register and changes only on a completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else if (w_wrap) begin
            r_parity <= xor_reduce(w_shifted);
        end else begin
            r_parity <= r_parity;
        end
    end

    assign parity = r_parity;
`endif

    assign so   = r_so;
    assign cnt  = r_cnt;
    assign co   = r_co;
    assign word = r_word;
    assign sout = dir ? r_so[0] : r_so[WIDTH-1];

endmodule

// File: doc/shift_counter_register.md
# shift_counter_register

Parametrised serial-in/serial-out shift register with an integrated bit counter and frame-complete strobe. It is the generalised successor of the 8-bit counting shift register, adding configurable width, shift direction, parallel load, a serial output and a held copy of the last completed word. It sits between a serial bit source and word-oriented logic, assembling WIDTH-bit frames and flagging each frame boundary.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CW, derived localparam, counter width = max(1, $clog2(WIDTH)); not overridable.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- en  in  1  shift enable; one shift per clock while high.
- set  in  1  synchronous clear of register, counter and frame state.
- load  in  1  synchronous parallel load from pin.
- dir  in  1  0 = shift toward MSB, si enters bit 0; 1 = shift toward LSB, si enters bit WIDTH-1.
- si  in  1  serial data in.
- pin  in  WIDTH  parallel load data.
- so  out  WIDTH  shift register contents.
- sout  out  1  bit leaving the register: so[WIDTH-1] when dir=0, so[0] when dir=1; combinational from so and dir.
- cnt  out  CW  shifts taken in the current frame, 0..WIDTH-1.
- co  out  1  registered one-cycle frame-complete pulse.
- word  out  WIDTH  last completed frame, held until the next completion.
- parity  out  1  only when SHREG_PARITY_EN is defined (see Configuration).

## Operation
- Per-edge priority: rst (async) > set > load > en > hold.
- rst low: so=0, cnt=0, co=0, word=0, parity=0 immediately, independent of clk.
- set=1: so=0, cnt=0, co=0; word and parity keep their values.
- load=1 (set=0): so=pin, cnt=0, co=0; word unchanged. en is ignored on that edge.
- en=1 (set=0, load=0): shift one bit in per dir. cnt = (cnt==WIDTH-1) ? 0 : cnt+1. Wrap is explicit, so non-power-of-two WIDTH is correct.
- Frame completion: on the shift edge where cnt goes WIDTH-1 -> 0, co=1 and word = post-shift value of so. On every other edge co=0.
- en=0 with no set/load: so, cnt and word hold, and co drops to 0.
- dir may change between shifts. A frame may mix directions; the counter is unaffected.

## Timing
- Shift latency: si is sampled at the edge, and so/cnt update at that same edge.
- co is high for exactly one clock period after the WIDTH-th consecutive enabled shift since the last set, load or reset. It is never high for two consecutive cycles unless WIDTH shifts occur in between.
- Back-to-back frames: with en held high, co pulses every WIDTH cycles, and word updates in the same cycles.
- Reset released asynchronously: the first shift may occur at the first rising edge after rst rises.
- set or load on the wrap edge: completion is suppressed. co=0 and word is not updated.

## Configuration
- SHREG_PARITY_EN defined: adds output port parity, a register that loads XOR-reduce of the new word on each frame completion. It resets to 0 and holds otherwise.
- SHREG_PARITY_EN undefined: the parity port and its register are absent, and all other behaviour is identical.

## Test plan
- Async reset: with WIDTH=8, after 5 shifts, drive rst=0 between edges. so=0, cnt=0, co=0 and word=0 before the next edge.
- dir=0, en=1, si=1,0,1,1,0,0,1,0 over 8 edges. so=8'b10110010, cnt=0, co=1 for one cycle, word=8'hB2. With the macro, parity=0.
- dir=1, same si sequence. so=8'b01001101, word=8'h4D, co=1 for one cycle.
- load with pin=8'hA5 and en=1 at cnt=3. so=8'hA5, cnt=0, co=0. Then dir=0, si=0 for 4 shifts gives sout sequence 1,0,1,0 before each shift.
- set=1 and load=1 together at cnt=5. so=0, cnt=0. Also, set on the wrap edge leaves co=0 and word unchanged.
- WIDTH=5 instance, en high continuously. co pulses at shifts 5 and 10, cnt stays in 0..4, and en low mid-frame holds cnt.
